mem_arbiter: RTL and testbench

Single-port memory arbiter that shares the `memory` block's one combinational-read / synchronous-write port between the instruction requester (`fetch`, read-only) and the data requester (load/store, read/write). One transaction is accepted per cycle using valid/ready handshakes. Data requests have fixed priority, and a starvation counter guarantees that fetch makes forward progress. Responses are registered and returned on a one-cycle-latency valid pulse per requester.

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-port comb-read, sync-write memory
module mem_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid_i,
    output logic              i_req_ready_o,
    input  logic [AWIDTH-1:0] i_addr_i,
    output logic              i_rsp_valid_o,
    output logic [DWIDTH-1:0] i_rsp_data_o,
    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_rsp_valid_o,
    output logic [DWIDTH-1:0] d_rsp_data_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0]     r_starve_cnt;
    logic              r_i_rsp_valid;
    logic [DWIDTH-1:0] r_i_rsp_data;
    logic              r_d_rsp_valid;
    logic [DWIDTH-1:0] r_d_rsp_data;

    logic w_fetch_first;
    logic w_gnt_i;
    logic w_gnt_d;

    // Data normally wins a conflict; fetch takes over once it has been denied long enough.
    assign w_fetch_first = (r_starve_cnt >= LIMIT);
    assign w_gnt_i = !rst && i_req_valid_i && (!d_req_valid_i || w_fetch_first);
    assign w_gnt_d = !rst && d_req_valid_i && (!i_req_valid_i || !w_fetch_first);

    assign i_req_ready_o = w_gnt_i;
    assign d_req_ready_o = w_gnt_d;

    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (w_gnt_i) begin
            mem_addr_o    = i_addr_i;
            mem_read_en_o = 1'b1;
        end else if (w_gnt_d) begin
            mem_addr_o = d_addr_i;
            if (d_we_i) begin
                mem_data_o     = d_wdata_i;
                mem_write_en_o = 1'b1;
            end else begin
                mem_read_en_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt  <= '0;
            r_i_rsp_valid <= 1'b0;
            r_i_rsp_data  <= '0;
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_data  <= '0;
        end else begin
            r_i_rsp_valid <= w_gnt_i;
            r_d_rsp_valid <= w_gnt_d;
            if (w_gnt_i) begin
                r_i_rsp_data <= mem_data_i;
            end
            if (w_gnt_d) begin
                r_d_rsp_data <= d_we_i ? '0 : mem_data_i;
            end
            if (!i_req_valid_i || w_gnt_i) begin
                r_starve_cnt <= '0;
            end else if (w_gnt_d && (r_starve_cnt != LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end
    end

    assign i_rsp_valid_o = r_i_rsp_valid;
    assign i_rsp_data_o  = r_i_rsp_data;
    assign d_rsp_valid_o = r_d_rsp_valid;
    assign d_rsp_data_o  = r_d_rsp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector table plus randomized run against a reference model
module tb_mem_arbiter;

    localparam int LIM = 4;
    localparam logic [31:0] A0   = 32'h0100_0000;
    localparam logic [31:0] A4   = 32'h0100_0004;
    localparam logic [31:0] A8   = 32'h0100_0008;
    localparam logic [31:0] A10  = 32'h0100_0010;
    localparam logic [31:0] W0   = 32'hfd01_0113;
    localparam logic [31:0] W1   = 32'h0211_2623;
    localparam logic [31:0] W2   = 32'h0001_2e23;
    localparam logic [31:0] DEAD = 32'hdead_beef;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid_i, i_req_ready_o, i_rsp_valid_o;
    logic [31:0] i_addr_i, i_rsp_data_o;
    logic        d_req_valid_i, d_req_ready_o, d_we_i, d_rsp_valid_o;
    logic [31:0] d_addr_i, d_wdata_i, d_rsp_data_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_read_en_o, mem_write_en_o;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid_i(i_req_valid_i), .i_req_ready_o(i_req_ready_o), .i_addr_i(i_addr_i),
        .i_rsp_valid_o(i_rsp_valid_o), .i_rsp_data_o(i_rsp_data_o),
        .d_req_valid_i(d_req_valid_i), .d_req_ready_o(d_req_ready_o), .d_we_i(d_we_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_data_o(d_rsp_data_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_data_i(mem_data_i)
    );

    // Memory environment: combinational read, write on posedge
    logic [31:0] mem [0:255];
    logic        tb_init;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
            mem[0] <= W0;
            mem[1] <= W1;
            mem[2] <= W2;
        end else if (mem_write_en_o) begin
            mem[mem_addr_o[9:2]] <= mem_data_o;
        end
    end

    assign mem_data_i = mem_read_en_o ? mem[mem_addr_o[9:2]] : 32'h0;

    typedef struct {
        bit          r;
        bit          iv;
        logic [31:0] ia;
        bit          dv;
        bit          dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        bit          e_ir;
        bit          e_dr;
        bit          e_irv;
        logic [31:0] e_ird;
        bit          e_drv;
        logic [31:0] e_drd;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] shadow [0:255];
    int          m_starve;
    logic [31:0] m_ird, m_drd;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic vec_t mk(bit r, bit iv, logic [31:0] ia, bit dv, bit dwe,
                                logic [31:0] da, logic [31:0] dwd, bit e_ir, bit e_dr,
                                bit e_irv, logic [31:0] e_ird, bit e_drv, logic [31:0] e_drd);
        vec_t v;
        v.r = r; v.iv = iv; v.ia = ia; v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.e_ir = e_ir; v.e_dr = e_dr; v.e_irv = e_irv; v.e_ird = e_ird;
        v.e_drv = e_drv; v.e_drd = e_drd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive, check grant-cycle outputs, step the model, check responses.
    task automatic run_cycle(input vec_t v, input bit use_tbl, output bit gi, output bit gd);
        bit          m_gi, m_gd, e_ir, e_dr, e_irv, e_drv;
        logic [31:0] e_ird, e_drd, e_addr;
        @(negedge clk);
        rst = v.r;
        i_req_valid_i = v.iv; i_addr_i = v.ia;
        d_req_valid_i = v.dv; d_we_i = v.dwe; d_addr_i = v.da; d_wdata_i = v.dwd;
        #1;
        m_gi = 1'b0;
        m_gd = 1'b0;
        if (!v.r) begin
            if (v.iv && v.dv) begin
                if (m_starve >= LIM) m_gi = 1'b1;
                else m_gd = 1'b1;
            end else begin
                m_gi = v.iv;
                m_gd = v.dv;
            end
        end
        if (v.r) begin
            m_ird = 32'h0;
            m_drd = 32'h0;
            m_starve = 0;
        end else begin
            if (m_gi) m_ird = shadow[v.ia[9:2]];
            if (m_gd) m_drd = v.dwe ? 32'h0 : shadow[v.da[9:2]];
            if (m_gd && v.dwe) shadow[v.da[9:2]] = v.dwd;
            if (!v.iv || m_gi) m_starve = 0;
            else if (m_starve < LIM) m_starve++;
        end
        if (use_tbl) begin
            e_ir = v.e_ir; e_dr = v.e_dr; e_irv = v.e_irv; e_ird = v.e_ird;
            e_drv = v.e_drv; e_drd = v.e_drd;
        end else begin
            e_ir = m_gi; e_dr = m_gd; e_irv = m_gi; e_ird = m_ird;
            e_drv = m_gd; e_drd = m_drd;
        end
        e_addr = e_ir ? v.ia : (e_dr ? v.da : 32'h0);
        chk("i_req_ready", {31'h0, i_req_ready_o}, {31'h0, e_ir});
        chk("d_req_ready", {31'h0, d_req_ready_o}, {31'h0, e_dr});
        chk("mem_read_en", {31'h0, mem_read_en_o}, {31'h0, e_ir || (e_dr && !v.dwe)});
        chk("mem_write_en", {31'h0, mem_write_en_o}, {31'h0, !e_ir && e_dr && v.dwe});
        chk("mem_addr", mem_addr_o, e_addr);
        if (!e_ir && e_dr && v.dwe) chk("mem_wdata", mem_data_o, v.dwd);
        else if (!e_ir && !e_dr) chk("mem_idle_data", mem_data_o, 32'h0);
        @(posedge clk);
        #1;
        chk("i_rsp_valid", {31'h0, i_rsp_valid_o}, {31'h0, e_irv});
        chk("i_rsp_data", i_rsp_data_o, e_ird);
        chk("d_rsp_valid", {31'h0, d_rsp_valid_o}, {31'h0, e_drv});
        chk("d_rsp_data", d_rsp_data_o, e_drd);
        gi = m_gi;
        gd = m_gd;
    endtask

    initial begin
        bit          gi, gd, ip, dp, pwe;
        logic [31:0] pia, pda, pwd;
        vec_t        v;

        rst = 1'b1; tb_init = 1'b1;
        i_req_valid_i = 1'b0; i_addr_i = '0;
        d_req_valid_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        for (int k = 0; k < 256; k++) shadow[k] = 32'h0;
        shadow[0] = W0; shadow[1] = W1; shadow[2] = W2;
        m_starve = 0; m_ird = 32'h0; m_drd = 32'h0;
        @(posedge clk);
        #1;
        tb_init = 1'b0;

        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 1, A4, 1, 1, A10, 32'h1111_1111, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A0, 0, 0, 0, 0, 1, 0, 1, W0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, W0, 0, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 1, A4, 1, 0, A8, 0, 0, 1, 0, W0, 1, W2));
        tbl.push_back(mk(0, 1, A4, 1, 0, A8, 0, 1, 0, 1, W1, 0, W2));
        tbl.push_back(mk(0, 1, A4, 1, 0, A8, 0, 0, 1, 0, W1, 1, W2));
        tbl.push_back(mk(0, 0, 0, 1, 0, A10, 0, 0, 1, 0, W1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, A10, DEAD, 0, 1, 0, W1, 1, 0));
        tbl.push_back(mk(0, 1, A10, 0, 0, 0, 0, 1, 0, 1, DEAD, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, A0, 0, 0, 1, 0, DEAD, 1, W0));
        tbl.push_back(mk(0, 0, 0, 1, 0, A4, 0, 0, 1, 0, DEAD, 1, W1));
        tbl.push_back(mk(0, 0, 0, 1, 0, A8, 0, 0, 1, 0, DEAD, 1, W2));
        tbl.push_back(mk(0, 1, A4, 0, 0, 0, 0, 1, 0, 1, W1, 0, W2));
        for (int k = 0; k < 2; k++) tbl.push_back(mk(1, 1, A8, 1, 0, A0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[k]) run_cycle(tbl[k], 1'b1, gi, gd);

        // Randomized traffic: requesters hold their payload until the model says accepted
        ip = 1'b0; dp = 1'b0; pwe = 1'b0;
        pia = A0; pda = A0; pwd = 32'h0;
        for (int n = 0; n < 600; n++) begin
            if (!ip && ($urandom_range(0, 3) != 0)) begin
                ip = 1'b1;
                pia = A0 | (32'($urandom_range(0, 15)) << 2);
            end
            if (!dp && ($urandom_range(0, 3) != 0)) begin
                dp = 1'b1;
                pwe = ($urandom_range(0, 2) == 0);
                pda = A0 | (32'($urandom_range(0, 15)) << 2);
                pwd = $urandom;
            end
            v = mk(($urandom_range(0, 63) == 0), ip, pia, dp, pwe, pda, pwd, 0, 0, 0, 0, 0, 0);
            run_cycle(v, 1'b0, gi, gd);
            if (gi) ip = 1'b0;
            if (gd) dp = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
